// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, frame length and default timing.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SEND,
    ST_ACK,
    ST_WAIT_REL
  } ps2_tx_state_t;

  localparam int unsigned PS2_FRAME_BITS     = 10;
  localparam int unsigned PS2_INHIBIT_CYCLES = 5000;
  localparam int unsigned PS2_TIMEOUT_CYCLES = 1000000;
  localparam int unsigned PS2_FILTER_LEN     = 8;

  // Bit n of the host frame: 0..7 data LSB first, 8 parity, 9 stop.
  function automatic logic ps2_frame_bit(input logic [7:0] data,
                                         input logic       par,
                                         input logic [3:0] idx);
    if (idx < 4'd8)       return data[idx[2:0]];
    else if (idx == 4'd8) return par;
    else                  return 1'b1;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 clock glitch filter: FILTER_LEN-deep shift register with hysteresis
// plus a falling-edge detector on the filtered clock.
module ps2_clk_filter
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = PS2_FILTER_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c,
  output logic filt,
  output logic neg_edge
);

  logic [FILTER_LEN-1:0] sr_q, sr_d;
  logic                  filt_q, filt_d;

  always_comb begin
    sr_d   = {sr_q[FILTER_LEN-2:0], ps2c};
    filt_d = filt_q;
    if (sr_d == '1)      filt_d = 1'b1;
    else if (sr_d == '0) filt_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q   <= '1;
      filt_q <= 1'b1;
    end else begin
      sr_q   <= sr_d;
      filt_q <= filt_d;
    end
  end

  assign filt     = filt_q;
  assign neg_edge = filt_q & ~filt_d;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with open-drain line enables.
// Optional device watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES,
  parameter int unsigned FILTER_LEN     = PS2_FILTER_LEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_busy,
  output logic       tx_done_tick,
  output logic       tx_err_tick,
  output logic       rx_inhibit
);

  localparam int unsigned ICW = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [ICW-1:0] INH_LAST = ICW'(INHIBIT_CYCLES - 1);
  localparam logic [3:0] LAST_IDX = 4'(PS2_FRAME_BITS - 1);

  if (INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 2 || FILTER_LEN < 2) begin : g_bad_param
    $error("ps2_host_tx: INHIBIT_CYCLES>=1, TIMEOUT_CYCLES>=2, FILTER_LEN>=2 required");
  end

  ps2_tx_state_t    state_q, state_d;
  logic [ICW-1:0]   cnt_q, cnt_d;
  logic [7:0]       data_q, data_d;
  logic             par_q, par_d;
  logic [3:0]       idx_q, idx_d;
  logic             dout_oe_q, dout_oe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             ps2c_filt;
  logic             neg_edge;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned WCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WCW-1:0] WD_LAST = WCW'(TIMEOUT_CYCLES - 1);
  logic [WCW-1:0]   wd_q, wd_d;
`endif

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clk     (clk),
    .reset   (reset),
    .ps2c    (ps2c),
    .filt    (ps2c_filt),
    .neg_edge(neg_edge)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    par_d     = par_q;
    idx_d     = idx_q;
    dout_oe_d = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (tx_start) begin
          data_d  = tx_data;
          par_d   = ~^tx_data;
          state_d = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d   = '0;
          state_d = ST_REQ;
        end else begin
          cnt_d = cnt_q + ICW'(1);
        end
      end
      ST_REQ: begin
        // Start bit: data stays low after the clock is released.
        dout_oe_d = 1'b1;
        idx_d     = '0;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        dout_oe_d = dout_oe_q;
        if (neg_edge) begin
          dout_oe_d = ~ps2_frame_bit(data_q, par_q, idx_q);
          idx_d     = idx_q + 4'd1;
          if (idx_q == LAST_IDX) state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (neg_edge) begin
          if (ps2d) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT_REL;
          end
        end
      end
      ST_WAIT_REL: begin
        if (ps2c_filt && ps2d) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    wd_d = wd_q + WCW'(1);
    if (state_q == ST_IDLE || state_q == ST_INHIBIT) begin
      wd_d = '0;
    end else if (wd_q == WD_LAST) begin
      // Watchdog overrides whatever the frame logic decided this cycle.
      state_d   = ST_IDLE;
      dout_oe_d = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b1;
    end
    if (neg_edge || state_d != state_q) wd_d = '0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      par_q     <= 1'b0;
      idx_q     <= '0;
      dout_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      par_q     <= par_d;
      idx_q     <= idx_d;
      dout_oe_q <= dout_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q      <= wd_d;
`endif
    end
  end

  assign tx_busy      = (state_q != ST_IDLE);
  assign rx_inhibit   = tx_busy;
  assign ps2c_oe      = (state_q == ST_INHIBIT) || (state_q == ST_REQ);
  assign ps2d_oe      = (state_q == ST_REQ) || dout_oe_q;
  assign tx_done_tick = done_q;
  assign tx_err_tick  = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model and a
// bit-level scoreboard of the expected host frame.
module tb_ps2_host_tx;

  localparam int unsigned INH  = 16;
  localparam int unsigned TMO  = 100;
  localparam int unsigned FLT  = 8;
  localparam int unsigned HALF = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2c, ps2d;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       ps2c_oe, ps2d_oe, tx_busy, tx_done_tick, tx_err_tick, rx_inhibit;
  logic       dev_clk, dev_data_low;

  assign ps2c = dev_clk & ~ps2c_oe;
  assign ps2d = ~dev_data_low & ~ps2d_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN    (FLT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2c        (ps2c),
    .ps2d        (ps2d),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .ps2c_oe     (ps2c_oe),
    .ps2d_oe     (ps2d_oe),
    .tx_busy     (tx_busy),
    .tx_done_tick(tx_done_tick),
    .tx_err_tick (tx_err_tick),
    .rx_inhibit  (rx_inhibit)
  );

  int unsigned cyc = 0;
  int unsigned done_cnt = 0, err_cnt = 0, err_cyc = 0;
  logic        done_busy = 1'b1;
  int unsigned pass_cnt = 0, total = 0;
  int unsigned last_fall_cyc = 0;
  bit          exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_done_tick) begin
      done_cnt  <= done_cnt + 1;
      done_busy <= tx_busy;
    end
    if (tx_err_tick) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, checks %0d/%0d", pass_cnt, total);
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [7:0] d);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    exp_q.push_back(~^d);
    exp_q.push_back(1'b1);
  endtask

  // Returns one cycle after the accepting edge, i.e. in cycle 1.
  task automatic start_tx(input logic [7:0] d);
    tick(1);
    tx_start = 1'b1;
    tx_data  = d;
    push_frame(d);
    tick(1);
    tx_start = 1'b0;
    tx_data  = 8'h00;
  endtask

  task automatic pulse_start_zero();
    tx_start = 1'b1;
    tx_data  = 8'h00;
    tick(1);
    tx_start = 1'b0;
  endtask

  task automatic wait_send();
    bit ok = 1'b0;
    for (int i = 0; i < int'(INH) + 50; i++) begin
      if (tx_busy && !ps2c_oe && ps2d_oe) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    check("req_release", ok, 1);
  endtask

  task automatic clock_bits(input int n, input int poke_at);
    logic e;
    tick(HALF);
    for (int i = 0; i < n; i++) begin
      dev_clk = 1'b0;
      last_fall_cyc = cyc;
      tick(HALF / 2);
      if (i == poke_at) pulse_start_zero();
      tick(HALF / 2);
      dev_clk = 1'b1;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
      check($sformatf("bit%0d", i), ps2d, e);
      tick(HALF);
    end
  endtask

  task automatic ack_phase(input bit do_ack);
    if (do_ack) dev_data_low = 1'b1;
    tick(4);
    dev_clk = 1'b0;
    tick(HALF);
    dev_clk = 1'b1;
    tick(HALF);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!tx_busy) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    check("busy_release", ok, 1);
    tick(2);
  endtask

  task automatic frame_result(input int unsigned d0, input int unsigned e0,
                              input int unsigned exp_done, input int unsigned exp_err);
    check("done_count", done_cnt - d0, exp_done);
    check("err_count", err_cnt - e0, exp_err);
    check("lines_released", {ps2c_oe, ps2d_oe}, 0);
    check("rx_inhibit_idle", rx_inhibit, 0);
    check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int unsigned d0, e0;
    bit ok;
    reset        = 1'b1;
    tx_start     = 1'b0;
    tx_data      = 8'h00;
    dev_clk      = 1'b1;
    dev_data_low = 1'b0;
    tick(3);
    check("rst_ps2c_oe", ps2c_oe, 0);
    check("rst_ps2d_oe", ps2d_oe, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done_tick, 0);
    check("rst_err", tx_err_tick, 0);
    check("rst_rx_inhibit", rx_inhibit, 0);
    reset = 1'b0;
    tick(FLT + 2);

    // 0xED with ack, plus inhibit/REQ cycle timing
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hED);
    check("busy_cycle1", tx_busy, 1);
    check("rx_inhibit_cycle1", rx_inhibit, 1);
    for (int k = 1; k <= 19; k++) begin
      check($sformatf("ps2c_oe_c%0d", k), ps2c_oe, (k <= 17) ? 1 : 0);
      check($sformatf("ps2d_oe_c%0d", k), ps2d_oe, (k >= 17) ? 1 : 0);
      tick(1);
    end
    wait_send();
    clock_bits(10, -1);
    ack_phase(1'b1);
    wait_idle();
    frame_result(d0, e0, 1, 0);
    check("busy_at_done", done_busy, 0);
    tick(20);

    // 0xF4 without ack; tx_start re-pulsed in INHIBIT and in SEND
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hF4);
    tick(5);
    pulse_start_zero();
    wait_send();
    clock_bits(10, 3);
    ack_phase(1'b0);
    wait_idle();
    frame_result(d0, e0, 0, 1);
    tick(60);
    check("no_second_frame_busy", tx_busy, 0);
    check("no_second_frame_ps2c", ps2c_oe, 0);

    // Reset asserted while bit 4 of 0x2C is on the line
    start_tx(8'h2C);
    wait_send();
    clock_bits(4, -1);
    dev_clk = 1'b0;
    tick(HALF / 2);
    check("bit4_driven", ps2d_oe, 1);
    #2 reset = 1'b1;
    #1;
    check("midrst_ps2c_oe", ps2c_oe, 0);
    check("midrst_ps2d_oe", ps2d_oe, 0);
    check("midrst_busy", tx_busy, 0);
    exp_q.delete();
    dev_clk = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(FLT + 4);

    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hFF);
    wait_send();
    clock_bits(10, -1);
    ack_phase(1'b1);
    wait_idle();
    frame_result(d0, e0, 1, 0);

`ifdef PS2_TX_TIMEOUT_EN
    // Device stops clocking after bit 3
    tick(20);
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'h12);
    wait_send();
    clock_bits(4, -1);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (err_cnt != e0) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    check("timeout_fired", ok, 1);
    check("timeout_latency", err_cyc - last_fall_cyc, FLT + TMO);
    exp_q.delete();
    tick(2);
    frame_result(d0, e0, 0, 1);
    check("timeout_busy", tx_busy, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
